pool2x2_stream: RTL

- Streaming 2x2 / stride-2 pooling engine for raster-order feature-map pixels, one pixel per valid_in beat.
- Successor to the 4-input pipelined max block: it takes a pixel stream instead of four pre-aligned inputs.
  - An internal half-row buffer does the vertical alignment.
  - Adds signed/unsigned compare, a max/average mode, and frame tracking.
- Sits between a conv layer's output stream and the next layer's input.

---
 rtl/pool2x2_stream_if.sv | 28 ++
 rtl/pool2x2_stream.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pool2x2_stream_if.sv
// pool2x2_stream_if: pixel stream in, pooled result stream out.
//   valid_in   : data_in carries a valid pixel this cycle
//   data_in    : pixel, raster order
//   pool_mode  : 0 = max, 1 = average (sampled on the first pixel of a frame)
//   valid_out  : max_data carries a pooled result this cycle
//   max_data   : pooled result
//   frame_done : marks the last result of a frame
// master = producer of pixels / consumer of results, slave = pooling engine.
interface pool2x2_stream_if #(
    parameter int data_width = 32
);
    logic                  valid_in;
    logic [data_width-1:0] data_in;
    logic                  pool_mode;
    logic                  valid_out;
    logic [data_width-1:0] max_data;
    logic                  frame_done;

    modport master (
        output valid_in, data_in, pool_mode,
        input  valid_out, max_data, frame_done
    );

    modport slave (
        input  valid_in, data_in, pool_mode,
        output valid_out, max_data, frame_done
    );
endinterface

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2 / stride-2 max or average pooling.
// Pixels arrive in raster order, one per valid_in beat. Even columns are
// held in a pending register, odd columns form a horizontal pair, even rows
// park that pair in a half-row buffer and odd rows combine it with the pair
// from the row above. The result is registered on the beat of the window's
// bottom-right pixel, so it appears one cycle later.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high
//   s     : stream interface (slave side), see pool2x2_stream_if
module pool2x2_stream #(
    parameter int data_width = 32,
    parameter int img_width  = 28,
    parameter int img_height = 28,
    parameter bit is_signed  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    pool2x2_stream_if.slave  s
);
    localparam int half  = img_width / 2;
    localparam int col_w = (img_width  > 1) ? $clog2(img_width)  : 1;
    localparam int row_w = (img_height > 1) ? $clog2(img_height) : 1;
    localparam int idx_w = (half > 1) ? $clog2(half) : 1;
    localparam int hw    = data_width + 1;   // horizontal pair width
    localparam int rw    = data_width + 2;   // 2x2 sum width

    localparam logic [col_w-1:0] col_last = col_w'(img_width - 1);
    localparam logic [row_w-1:0] row_last = row_w'(img_height - 1);

    // Sign- or zero-extend by one bit; extension preserves ordering, so
    // compares can be done on the widened values.
    function automatic logic [hw-1:0] ext_h(input logic [data_width-1:0] v);
        ext_h = {(is_signed ? v[data_width-1] : 1'b0), v};
    endfunction

    function automatic logic [rw-1:0] ext_r(input logic [hw-1:0] v);
        ext_r = {(is_signed ? v[hw-1] : 1'b0), v};
    endfunction

    function automatic logic gt_h(input logic [hw-1:0] a, input logic [hw-1:0] b);
        if (is_signed) gt_h = $signed(a) > $signed(b);
        else           gt_h = a > b;
    endfunction

    logic [col_w-1:0]      col;
    logic [row_w-1:0]      row;
    logic                  mode_reg;
    logic [data_width-1:0] pend;
    logic [hw-1:0]         row_buf [half];

    logic                  valid_q;
    logic [data_width-1:0] data_q;
    logic                  done_q;

    logic                  first_px;
    logic                  last_px;
    logic                  eff_mode;
    logic [idx_w-1:0]      idx;
    logic [hw-1:0]         pend_x, din_x, h_max, h_sum, h, above, r_max;
    logic [rw-1:0]         r_sum, r_avg;
    logic signed [rw-1:0]  r_sum_s, r_shr_s;
    logic [data_width-1:0] result;

    assign first_px = (row == '0) && (col == '0);
    assign last_px  = (row == row_last) && (col == col_last);
    // The first beat of a frame uses the live mode pin; mode_reg is only
    // loaded by that same beat.
    assign eff_mode = first_px ? s.pool_mode : mode_reg;
    assign idx      = idx_w'(col >> 1);

    // NOTE: every signal written here gets a value on every path (defaults
    // first), so no latches are inferred.
    always_comb begin
        pend_x  = ext_h(pend);
        din_x   = ext_h(s.data_in);
        h_max   = gt_h(pend_x, din_x) ? pend_x : din_x;
        h_sum   = pend_x + din_x;
        h       = eff_mode ? h_sum : h_max;
        above   = row_buf[idx];
        r_max   = gt_h(above, h) ? above : h;
        r_sum   = ext_r(above) + ext_r(h);
        r_sum_s = r_sum;
        r_shr_s = r_sum_s >>> 2;
        // Shift right by two is floor division by four in both encodings.
        r_avg   = is_signed ? rw'(r_shr_s) : (r_sum >> 2);
        result  = eff_mode ? r_avg[data_width-1:0] : r_max[data_width-1:0];
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            mode_reg <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (s.valid_in) begin
                if (first_px) mode_reg <= s.pool_mode;
                if (col[0] && row[0]) begin
                    valid_q <= 1'b1;
                    data_q  <= result;
                    done_q  <= last_px;
                end
                if (col == col_last) begin
                    col <= '0;
                    row <= (row == row_last) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // NOTE: the pixel datapath has no reset; its contents are always written
    // before being read within a frame, so clearing it would be wasted logic.
    always_ff @(posedge clk) begin
        if (s.valid_in) begin
            if (!col[0])     pend         <= s.data_in;
            else if (!row[0]) row_buf[idx] <= h;
        end
    end

    assign s.valid_out  = valid_q;
    assign s.max_data   = data_q;
    assign s.frame_done = done_q;
endmodule
